// File: rtl/vector_mac_stream_if.sv
// Stream bundle for vector_mac_stream: input beat channel and result channel.
// The slave modport is the MAC's view; the master modport is the feeder's view.
interface vector_mac_stream_if #(
    parameter int DATA_W = 8,
    parameter int WGT_W  = 8,
    parameter int LENGTH = 16,
    parameter int ACC_W  = 24
);
    logic                          mode;
    logic                          in_valid;
    logic                          in_ready;
    logic                          in_last;
    logic [LENGTH-1:0][DATA_W-1:0] in_data;
    logic [LENGTH-1:0][WGT_W-1:0]  in_weight;
    logic                          out_valid;
    logic                          out_ready;
    logic [LENGTH-1:0][ACC_W-1:0]  out_data;

    modport master (
        output mode, in_valid, in_last, in_data, in_weight, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  mode, in_valid, in_last, in_data, in_weight, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/vector_mac_stream.sv
// Streaming LENGTH-lane multiply / accumulate, 2-stage pipeline with valid/ready.
// Define VMAC_SATURATE_EN to clamp accumulate results; otherwise they wrap.
module vmac_lane #(
    parameter int DATA_W = 8,
    parameter int WGT_W  = 8,
    parameter int ACC_W  = 24
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              s1_en_i,
    input  logic              s2_en_i,
    input  logic              s2_mode_i,
    input  logic              s2_last_i,
    input  logic [DATA_W-1:0] act_i,
    input  logic [WGT_W-1:0]  wgt_i,
    output logic [ACC_W-1:0]  out_o,
    output logic              ovf_o
);
    localparam int PW = DATA_W + WGT_W;

    logic signed [PW-1:0]    a_ext, w_ext, prod_d, prod_q;
    logic signed [ACC_W-1:0] acc_d, acc_q, out_d, out_q, lim;
    logic signed [ACC_W:0]   sum;
    logic                    rng_err;

    always_comb begin
        a_ext   = {{WGT_W{1'b0}}, act_i};
        w_ext   = {{DATA_W{wgt_i[WGT_W-1]}}, wgt_i};
        prod_d  = a_ext * w_ext;
        // One guard bit is enough to see any single-step overflow exactly.
        sum     = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod_q);
        rng_err = sum[ACC_W] != sum[ACC_W-1];
        ovf_o   = s2_en_i && s2_mode_i && rng_err;
`ifdef VMAC_SATURATE_EN
        if (rng_err)
            lim = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            lim = sum[ACC_W-1:0];
`else
        lim = sum[ACC_W-1:0];
`endif
        acc_d = acc_q;
        out_d = out_q;
        if (s2_en_i) begin
            if (!s2_mode_i) begin
                out_d = ACC_W'(prod_q);
            end else if (s2_last_i) begin
                out_d = lim;
                acc_d = '0;
            end else begin
                acc_d = lim;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prod_q <= '0;
            acc_q  <= '0;
            out_q  <= '0;
        end else if (clr) begin
            prod_q <= '0;
            acc_q  <= '0;
            out_q  <= '0;
        end else begin
            if (s1_en_i) prod_q <= prod_d;
            acc_q <= acc_d;
            out_q <= out_d;
        end
    end

    assign out_o = out_q;
endmodule

module vector_mac_stream #(
    parameter int DATA_W = 8,
    parameter int WGT_W  = 8,
    parameter int LENGTH = 16,
    parameter int ACC_W  = 24
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      clr,
    vector_mac_stream_if.slave        bus,
    output logic                      ovf
);
    localparam int STAGES = 2;

    // [0]: multiply stage holds a beat, [1]: out_data holds a result
    logic [STAGES-1:0] vld_pipe_q;
    logic              s1_mode_q, s1_last_q, pkt_open_q, ovf_q;
    logic              stall, accept, eff_mode, s2_en;
    logic [LENGTH-1:0] lane_ovf;

    assign stall         = vld_pipe_q[1] && !bus.out_ready;
    assign accept        = bus.in_valid && !stall && !clr;
    assign eff_mode      = pkt_open_q | bus.mode;
    assign s2_en         = vld_pipe_q[0] && !stall && !clr;
    assign bus.in_ready  = !stall;
    assign bus.out_valid = vld_pipe_q[1];
    assign ovf           = ovf_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe_q <= '0;
            s1_mode_q  <= 1'b0;
            s1_last_q  <= 1'b0;
            pkt_open_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (clr) begin
            vld_pipe_q <= '0;
            s1_mode_q  <= 1'b0;
            s1_last_q  <= 1'b0;
            pkt_open_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (|lane_ovf) ovf_q <= 1'b1;
            if (accept) begin
                s1_mode_q <= eff_mode;
                s1_last_q <= bus.in_last;
                if (eff_mode) pkt_open_q <= !bus.in_last;
            end
            if (!stall) begin
                vld_pipe_q[0] <= accept;
                // Non-last accumulate beats only update the sums.
                vld_pipe_q[1] <= vld_pipe_q[0] && (!s1_mode_q || s1_last_q);
            end
        end
    end

    for (genvar i = 0; i < LENGTH; i++) begin : g_lane
        vmac_lane #(
            .DATA_W(DATA_W),
            .WGT_W (WGT_W),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk      (clk),
            .rstn     (rstn),
            .clr      (clr),
            .s1_en_i  (accept),
            .s2_en_i  (s2_en),
            .s2_mode_i(s1_mode_q),
            .s2_last_i(s1_last_q),
            .act_i    (bus.in_data[i]),
            .wgt_i    (bus.in_weight[i]),
            .out_o    (bus.out_data[i]),
            .ovf_o    (lane_ovf[i])
        );
    end
endmodule

// File: tb/tb_vector_mac_stream.sv
// Scoreboard bench for vector_mac_stream: tests push expected vectors on accept,
// a negedge monitor pops and compares every output transfer.
module tb_vector_mac_stream;
    localparam int DATA_W = 8;
    localparam int WGT_W  = 8;
    localparam int LENGTH = 16;
    localparam int ACC_W  = 24;

    typedef logic [LENGTH-1:0][DATA_W-1:0] dvec_t;
    typedef logic [LENGTH-1:0][WGT_W-1:0]  wvec_t;
    typedef logic [LENGTH-1:0][ACC_W-1:0]  ovec_t;

    logic  clk = 1'b0;
    logic  rstn = 1'b0;
    logic  clr = 1'b0;
    logic  ovf;
    int    errors = 0;
    int    checks = 0;
    int    n_out  = 0;
    ovec_t exp_q[$];

    vector_mac_stream_if #(.DATA_W(DATA_W), .WGT_W(WGT_W), .LENGTH(LENGTH), .ACC_W(ACC_W)) bus();

    vector_mac_stream #(.DATA_W(DATA_W), .WGT_W(WGT_W), .LENGTH(LENGTH), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rstn(rstn),
        .clr (clr),
        .bus (bus.slave),
        .ovf (ovf)
    );

    always #5 clk = ~clk;

    // Output monitor: a transfer happens on the posedge following this negedge.
    always @(negedge clk) begin
        if (rstn && !clr && bus.out_valid && bus.out_ready) begin
            n_out++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got=%h", bus.out_data);
            end else begin
                ovec_t e;
                e = exp_q.pop_front();
                if (bus.out_data !== e) begin
                    errors++;
                    $display("FAIL out_data got=%h want=%h", bus.out_data, e);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic m, input logic l, input dvec_t d, input wvec_t w);
        logic hs;
        int   n;
        bus.in_valid  = 1'b1;
        bus.mode      = m;
        bus.in_last   = l;
        bus.in_data   = d;
        bus.in_weight = w;
        n = 0;
        do begin
            @(negedge clk);
            hs = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!hs && n < 1000);
        if (!hs) begin
            errors++;
            checks++;
            $display("FAIL send_timeout in_ready=%b want=1", bus.in_ready);
        end
        bus.in_valid = 1'b0;
        bus.mode     = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
    endtask

    function automatic ovec_t fill(input int v0, input int step);
        ovec_t e;
        for (int i = 0; i < LENGTH; i++) e[i] = ACC_W'(v0 + step * i);
        return e;
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 3;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b want=0", bus.out_valid); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b want=0", ovf); end
        if (bus.out_data !== '0) begin errors++; $display("FAIL rst_out_data got=%h want=0", bus.out_data); end
        rstn = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_elementwise();
        dvec_t d;
        wvec_t w;
        ovec_t e;
        for (int i = 0; i < LENGTH; i++) begin
            d[i] = DATA_W'($urandom_range(0, 255));
            w[i] = WGT_W'($urandom_range(0, 255));
        end
        d[0] = 8'd255; w[0] = 8'h80;
        d[1] = 8'd3;   w[1] = 8'd5;
        for (int i = 0; i < LENGTH; i++) e[i] = ACC_W'(int'(d[i]) * int'($signed(w[i])));
        send(1'b0, 1'b1, d, w);
        exp_q.push_back(e);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ew_early got=%b want=0", bus.out_valid); end
        @(posedge clk);
        #1;
        checks += 3;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ew_latency got=%b want=1", bus.out_valid); end
        if ($signed(bus.out_data[0]) !== -32640) begin errors++; $display("FAIL ew_lane0 got=%0d want=-32640", $signed(bus.out_data[0])); end
        if ($signed(bus.out_data[1]) !== 15) begin errors++; $display("FAIL ew_lane1 got=%0d want=15", $signed(bus.out_data[1])); end
        wait_drain();
    endtask

    task automatic test_accumulate();
        dvec_t d;
        wvec_t w;
        int    n0;
        for (int i = 0; i < LENGTH; i++) begin d[i] = DATA_W'(i); w[i] = 8'd2; end
        n0 = n_out;
        for (int b = 0; b < 4; b++) send(1'b1, b == 3, d, w);
        exp_q.push_back(fill(0, 8));
        wait_drain();
        checks++;
        if (n_out - n0 != 1) begin errors++; $display("FAIL acc_count got=%0d want=1", n_out - n0); end
        for (int i = 0; i < LENGTH; i++) w[i] = 8'd3;
        send(1'b1, 1'b1, d, w);
        exp_q.push_back(fill(0, 3));
        wait_drain();
    endtask

    task automatic test_back_to_back();
        dvec_t d[8];
        wvec_t w[8];
        for (int b = 0; b < 8; b++)
            for (int i = 0; i < LENGTH; i++) begin
                d[b][i] = DATA_W'($urandom_range(0, 255));
                w[b][i] = WGT_W'($urandom_range(0, 255));
            end
        fork
            begin
                for (int b = 0; b < 8; b++) begin
                    ovec_t e;
                    for (int i = 0; i < LENGTH; i++) e[i] = ACC_W'(int'(d[b][i]) * int'($signed(w[b][i])));
                    send(1'b0, 1'b0, d[b], w[b]);
                    exp_q.push_back(e);
                end
            end
            begin
                ovec_t snap;
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                @(negedge clk);
                snap = bus.out_data;
                repeat (4) begin
                    @(negedge clk);
                    checks += 2;
                    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b want=0", bus.in_ready); end
                    if (bus.out_data !== snap) begin errors++; $display("FAIL stall_stable got=%h want=%h", bus.out_data, snap); end
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_drain();
    endtask

    task automatic test_overflow();
        dvec_t d;
        wvec_t w;
        int    want;
        for (int i = 0; i < LENGTH; i++) begin d[i] = 8'd255; w[i] = 8'd127; end
`ifdef VMAC_SATURATE_EN
        want = 8388607;
`else
        want = -7061716;
`endif
        for (int b = 0; b < 300; b++) send(1'b1, b == 299, d, w);
        exp_q.push_back(fill(want, 0));
        wait_drain();
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b want=1", ovf); end
    endtask

    task automatic test_mode_latch();
        dvec_t d;
        wvec_t w;
        int    n0;
        for (int i = 0; i < LENGTH; i++) begin d[i] = DATA_W'(i + 1); w[i] = 8'd1; end
        n0 = n_out;
        send(1'b1, 1'b0, d, w);
        send(1'b0, 1'b0, d, w);
        send(1'b0, 1'b1, d, w);
        exp_q.push_back(fill(3, 3));
        wait_drain();
        checks++;
        if (n_out - n0 != 1) begin errors++; $display("FAIL latch_count got=%0d want=1", n_out - n0); end
    endtask

    task automatic test_flush(input logic use_clr);
        dvec_t d;
        wvec_t w;
        for (int i = 0; i < LENGTH; i++) begin d[i] = 8'd50; w[i] = 8'd50; end
        send(1'b1, 1'b0, d, w);
        send(1'b1, 1'b0, d, w);
        if (use_clr) clr = 1'b1; else rstn = 1'b0;
        @(posedge clk);
        #1;
        clr  = 1'b0;
        rstn = 1'b1;
        checks += 2;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid clr=%b got=%b want=0", use_clr, bus.out_valid); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL flush_ovf clr=%b got=%b want=0", use_clr, ovf); end
        for (int i = 0; i < LENGTH; i++) begin d[i] = 8'd1; w[i] = 8'd1; end
        send(1'b1, 1'b1, d, w);
        exp_q.push_back(fill(1, 0));
        wait_drain();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.mode      = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_data   = '0;
        bus.in_weight = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_elementwise();
        test_accumulate();
        test_back_to_back();
        test_overflow();
        test_flush(1'b0);
        test_mode_latch();
        test_flush(1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
